// File: rtl/z80_regfile_pkg.sv
// Shared register-select encodings, reset defaults and pair-to-byte mapping
// for the banked Z80 register file.
package z80_regfile_pkg;

  typedef enum logic [3:0] {
    R8_A   = 4'd0,
    R8_B   = 4'd1,
    R8_C   = 4'd2,
    R8_D   = 4'd3,
    R8_E   = 4'd4,
    R8_H   = 4'd5,
    R8_L   = 4'd6,
    R8_F   = 4'd7,
    R8_IXH = 4'd8,
    R8_IXL = 4'd9,
    R8_IYH = 4'd10,
    R8_IYL = 4'd11,
    R8_I   = 4'd12,
    R8_R   = 4'd13
  } reg8_sel_t;

  typedef enum logic [2:0] {
    R16_BC = 3'd0,
    R16_DE = 3'd1,
    R16_HL = 3'd2,
    R16_SP = 3'd3,
    R16_AF = 3'd4,
    R16_IX = 3'd5,
    R16_IY = 3'd6,
    R16_PC = 3'd7
  } reg16_sel_t;

  localparam logic [15:0] SP_RESET_DEF  = 16'hFFFE;
  localparam logic [15:0] PC_RESET_DEF  = 16'h0000;
  localparam int unsigned NUM_BYTE_REGS = 14;
  localparam int unsigned GPR_BYTES     = 6;
  localparam logic [3:0]  NO_BYTE       = 4'd15;

  // SP and PC have no byte view, so they map to NO_BYTE
  function automatic logic [3:0] pair_hi(input reg16_sel_t s);
    case (s)
      R16_BC:  pair_hi = 4'(R8_B);
      R16_DE:  pair_hi = 4'(R8_D);
      R16_HL:  pair_hi = 4'(R8_H);
      R16_AF:  pair_hi = 4'(R8_A);
      R16_IX:  pair_hi = 4'(R8_IXH);
      R16_IY:  pair_hi = 4'(R8_IYH);
      default: pair_hi = NO_BYTE;
    endcase
  endfunction

  function automatic logic [3:0] pair_lo(input reg16_sel_t s);
    case (s)
      R16_BC:  pair_lo = 4'(R8_C);
      R16_DE:  pair_lo = 4'(R8_E);
      R16_HL:  pair_lo = 4'(R8_L);
      R16_AF:  pair_lo = 4'(R8_F);
      R16_IX:  pair_lo = 4'(R8_IXL);
      R16_IY:  pair_lo = 4'(R8_IYL);
      default: pair_lo = NO_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/z80_gpr_bank.sv
// One B/C/D/E/H/L bank with per-byte write enables and the DE<->HL swap;
// a byte write beats the swap for that byte.
module z80_gpr_bank
  import z80_regfile_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [GPR_BYTES-1:0]     we,
  input  logic [8*GPR_BYTES-1:0]   wd,
  input  logic                     swap,
  output logic [15:0]              bc,
  output logic [15:0]              de,
  output logic [15:0]              hl
);

  logic [7:0] b_q, c_q, d_q, e_q, h_q, l_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      b_q <= 8'h00;
      c_q <= 8'h00;
      d_q <= 8'h00;
      e_q <= 8'h00;
      h_q <= 8'h00;
      l_q <= 8'h00;
    end else begin
      if (we[0]) b_q <= wd[7:0];
      if (we[1]) c_q <= wd[15:8];
      d_q <= we[2] ? wd[23:16] : (swap ? h_q : d_q);
      e_q <= we[3] ? wd[31:24] : (swap ? l_q : e_q);
      h_q <= we[4] ? wd[39:32] : (swap ? d_q : h_q);
      l_q <= we[5] ? wd[47:40] : (swap ? e_q : l_q);
    end
  end

  assign bc = {b_q, c_q};
  assign de = {d_q, e_q};
  assign hl = {h_q, l_q};

endmodule

// File: rtl/z80_regfile_banked.sv
// Banked Z80 register file: main/alternate banks, IX/IY, I/R, exchanges,
// 16-bit inc/dec unit, PC increment and R refresh, with combinational read ports.
module z80_regfile_banked
  import z80_regfile_pkg::*;
#(
  parameter int unsigned NUM_RD8     = 2,
  parameter int unsigned NUM_RD16    = 2,
  parameter bit          HAS_ALT_SET = 1'b1,
  parameter bit          HAS_INDEX   = 1'b1,
  parameter logic [15:0] SP_RESET    = SP_RESET_DEF,
  parameter logic [15:0] PC_RESET    = PC_RESET_DEF
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr8_en,
  input  logic [3:0]              wr8_sel,
  input  logic [7:0]              wr8_data,
  input  logic                    wr16_en,
  input  logic [2:0]              wr16_sel,
  input  logic [15:0]             wr16_data,
  input  logic                    flags_we,
  input  logic [7:0]              flags_in,
  input  logic                    idu_en,
  input  logic                    idu_dec,
  input  logic [2:0]              idu_sel,
  input  logic                    pc_inc,
  input  logic                    r_inc,
  input  logic                    ex_af,
  input  logic                    exx,
  input  logic                    ex_de_hl,
  input  logic [4*NUM_RD8-1:0]    rd8_sel,
  output logic [8*NUM_RD8-1:0]    rd8_data,
  input  logic [3*NUM_RD16-1:0]   rd16_sel,
  output logic [16*NUM_RD16-1:0]  rd16_data,
  output logic [7:0]              A,
  output logic [7:0]              F,
  output logic [15:0]             PC,
  output logic [15:0]             SP,
  output logic                    af_bank,
  output logic                    main_bank
);

  logic [7:0]  a_q [2];
  logic [7:0]  f_q [2];
  logic [15:0] ix_q, iy_q, sp_q, pc_q;
  logic [7:0]  i_q, r_q;
  logic [15:0] bc_w [2];
  logic [15:0] de_w [2];
  logic [15:0] hl_w [2];
  logic [7:0]  cur8  [16];
  logic [15:0] cur16 [8];
  logic        byte_we [NUM_BYTE_REGS];
  logic [7:0]  byte_wd [NUM_BYTE_REGS];
  logic [15:0] idu_res, sp_nx, pc_nx;
  logic [3:0]  idu_hi, idu_lo, wr_hi, wr_lo;
  logic [GPR_BYTES-1:0]   gpr_we;
  logic [8*GPR_BYTES-1:0] gpr_wd;

  // Current-state views; entries 14/15 are the invalid byte selects
  always_comb begin
    cur8[0]  = a_q[af_bank];
    cur8[1]  = bc_w[main_bank][15:8];
    cur8[2]  = bc_w[main_bank][7:0];
    cur8[3]  = de_w[main_bank][15:8];
    cur8[4]  = de_w[main_bank][7:0];
    cur8[5]  = hl_w[main_bank][15:8];
    cur8[6]  = hl_w[main_bank][7:0];
    cur8[7]  = f_q[af_bank];
    cur8[8]  = ix_q[15:8];
    cur8[9]  = ix_q[7:0];
    cur8[10] = iy_q[15:8];
    cur8[11] = iy_q[7:0];
    cur8[12] = i_q;
    cur8[13] = r_q;
    cur8[14] = 8'h00;
    cur8[15] = 8'h00;
    cur16[0] = bc_w[main_bank];
    cur16[1] = de_w[main_bank];
    cur16[2] = hl_w[main_bank];
    cur16[3] = sp_q;
    cur16[4] = {a_q[af_bank], f_q[af_bank]};
    cur16[5] = ix_q;
    cur16[6] = iy_q;
    cur16[7] = pc_q;
  end

  assign idu_hi = pair_hi(reg16_sel_t'(idu_sel));
  assign idu_lo = pair_lo(reg16_sel_t'(idu_sel));
  assign wr_hi  = pair_hi(reg16_sel_t'(wr16_sel));
  assign wr_lo  = pair_lo(reg16_sel_t'(wr16_sel));

  // Write arbitration: sources applied lowest priority first, later ones override
  always_comb begin
    byte_we = '{default: 1'b0};
    byte_wd = '{default: 8'h00};
    sp_nx   = sp_q;
    pc_nx   = pc_q;
    idu_res = idu_dec ? cur16[idu_sel] - 16'd1 : cur16[idu_sel] + 16'd1;
    if (pc_inc) pc_nx = pc_q + 16'd1;
    if (idu_en) begin
      if (idu_hi != NO_BYTE) begin
        byte_we[idu_hi] = 1'b1;
        byte_wd[idu_hi] = idu_res[15:8];
        byte_we[idu_lo] = 1'b1;
        byte_wd[idu_lo] = idu_res[7:0];
      end
      if (idu_sel == 3'(R16_SP)) sp_nx = idu_res;
      if (idu_sel == 3'(R16_PC)) pc_nx = idu_res;
    end
    if (flags_we) begin
      byte_we[R8_F] = 1'b1;
      byte_wd[R8_F] = flags_in;
    end
    if (wr8_en && wr8_sel < 4'(NUM_BYTE_REGS)) begin
      byte_we[wr8_sel] = 1'b1;
      byte_wd[wr8_sel] = wr8_data;
    end
    if (wr16_en) begin
      if (wr_hi != NO_BYTE) begin
        byte_we[wr_hi] = 1'b1;
        byte_wd[wr_hi] = wr16_data[15:8];
        byte_we[wr_lo] = 1'b1;
        byte_wd[wr_lo] = wr16_data[7:0];
      end
      if (wr16_sel == 3'(R16_SP)) sp_nx = wr16_data;
      if (wr16_sel == 3'(R16_PC)) pc_nx = wr16_data;
    end
  end

  for (genvar k = 0; k < GPR_BYTES; k++) begin : g_gpr_map
    assign gpr_we[k]          = byte_we[k+1];
    assign gpr_wd[8*k +: 8]   = byte_wd[k+1];
  end

  // Only the bank active at the start of the cycle sees writes and the swap
  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b == 0 || HAS_ALT_SET) begin : g_inst
      z80_gpr_bank u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (gpr_we & {GPR_BYTES{main_bank == 1'(b)}}),
        .wd    (gpr_wd),
        .swap  (ex_de_hl && (main_bank == 1'(b))),
        .bc    (bc_w[b]),
        .de    (de_w[b]),
        .hl    (hl_w[b])
      );
    end else begin : g_none
      assign bc_w[b] = 16'h0000;
      assign de_w[b] = 16'h0000;
      assign hl_w[b] = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q[0]    <= 8'h00;
      a_q[1]    <= 8'h00;
      f_q[0]    <= 8'h00;
      f_q[1]    <= 8'h00;
      ix_q      <= 16'h0000;
      iy_q      <= 16'h0000;
      i_q       <= 8'h00;
      r_q       <= 8'h00;
      sp_q      <= SP_RESET;
      pc_q      <= PC_RESET;
      af_bank   <= 1'b0;
      main_bank <= 1'b0;
    end else begin
      if (byte_we[R8_A]) a_q[af_bank] <= byte_wd[R8_A];
      if (byte_we[R8_F]) f_q[af_bank] <= byte_wd[R8_F];
      if (HAS_INDEX) begin
        if (byte_we[R8_IXH]) ix_q[15:8] <= byte_wd[R8_IXH];
        if (byte_we[R8_IXL]) ix_q[7:0]  <= byte_wd[R8_IXL];
        if (byte_we[R8_IYH]) iy_q[15:8] <= byte_wd[R8_IYH];
        if (byte_we[R8_IYL]) iy_q[7:0]  <= byte_wd[R8_IYL];
      end
      if (byte_we[R8_I]) i_q <= byte_wd[R8_I];
      // Refresh counts in the low 7 bits only; bit 7 is software-owned
      if (byte_we[R8_R])  r_q <= byte_wd[R8_R];
      else if (r_inc)     r_q <= {r_q[7], r_q[6:0] + 7'd1};
      sp_q <= sp_nx;
      pc_q <= pc_nx;
      if (HAS_ALT_SET) begin
        if (ex_af) af_bank   <= ~af_bank;
        if (exx)   main_bank <= ~main_bank;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD8; p++) begin : g_rd8
    assign rd8_data[8*p +: 8] = cur8[rd8_sel[4*p +: 4]];
  end

  for (genvar p = 0; p < NUM_RD16; p++) begin : g_rd16
    assign rd16_data[16*p +: 16] = cur16[rd16_sel[3*p +: 3]];
  end

  assign A  = a_q[af_bank];
  assign F  = f_q[af_bank];
  assign PC = pc_q;
  assign SP = sp_q;

endmodule

// File: tb/tb_z80_regfile_banked.sv
// Scoreboard bench: each cycle the stimulus queues expected pre-edge state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_z80_regfile_banked;
  import z80_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr8_en, wr16_en, flags_we, idu_en, idu_dec, pc_inc, r_inc;
  logic        ex_af, exx, ex_de_hl;
  logic [3:0]  wr8_sel;
  logic [7:0]  wr8_data, flags_in;
  logic [2:0]  wr16_sel, idu_sel;
  logic [15:0] wr16_data;
  logic [7:0]  rd8_sel;
  logic [15:0] rd8_data;
  logic [5:0]  rd16_sel;
  logic [31:0] rd16_data;
  logic [7:0]  A, F;
  logic [15:0] PC, SP;
  logic        af_bank, main_bank;

  z80_regfile_banked dut (
    .clk(clk), .reset(reset),
    .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_data(wr8_data),
    .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_data(wr16_data),
    .flags_we(flags_we), .flags_in(flags_in),
    .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel),
    .pc_inc(pc_inc), .r_inc(r_inc), .ex_af(ex_af), .exx(exx), .ex_de_hl(ex_de_hl),
    .rd8_sel(rd8_sel), .rd8_data(rd8_data), .rd16_sel(rd16_sel), .rd16_data(rd16_data),
    .A(A), .F(F), .PC(PC), .SP(SP), .af_bank(af_bank), .main_bank(main_bank)
  );

  always #5 clk = ~clk;

  localparam int K_RD8 = 0, K_RD16 = 1, K_A = 2, K_F = 3, K_PC = 4, K_SP = 5, K_AFB = 6, K_MB = 7;

  typedef struct {
    int          kind;
    int          port;
    logic [15:0] exp;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] mon_got;
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_RD8:   mon_got = {8'h00, rd8_data[8*mon_e.port +: 8]};
        K_RD16:  mon_got = rd16_data[16*mon_e.port +: 16];
        K_A:     mon_got = {8'h00, A};
        K_F:     mon_got = {8'h00, F};
        K_PC:    mon_got = PC;
        K_SP:    mon_got = SP;
        K_AFB:   mon_got = {15'h0000, af_bank};
        default: mon_got = {15'h0000, main_bank};
      endcase
      checks++;
      if (mon_got !== mon_e.exp) begin
        errors++;
        $display("FAIL cyc%0d kind=%0d port=%0d got=%h exp=%h",
                 mon_e.cyc, mon_e.kind, mon_e.port, mon_got, mon_e.exp);
      end
    end
  end

  task automatic clr_ops();
    wr8_en = 1'b0; wr8_sel = 4'h0; wr8_data = 8'h00;
    wr16_en = 1'b0; wr16_sel = 3'h0; wr16_data = 16'h0000;
    flags_we = 1'b0; flags_in = 8'h00;
    idu_en = 1'b0; idu_dec = 1'b0; idu_sel = 3'h0;
    pc_inc = 1'b0; r_inc = 1'b0; ex_af = 1'b0; exx = 1'b0; ex_de_hl = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_no++;
    clr_ops();
  endtask

  task automatic ex8(input int p, input logic [3:0] s, input logic [7:0] v);
    rd8_sel[4*p +: 4] = s;
    sb.push_back('{K_RD8, p, {8'h00, v}, cyc_no});
  endtask

  task automatic ex16(input int p, input logic [2:0] s, input logic [15:0] v);
    rd16_sel[3*p +: 3] = s;
    sb.push_back('{K_RD16, p, v, cyc_no});
  endtask

  task automatic exo(input int k, input logic [15:0] v);
    sb.push_back('{k, 0, v, cyc_no});
  endtask

  task automatic w8(input logic [3:0] s, input logic [7:0] d);
    wr8_en = 1'b1; wr8_sel = s; wr8_data = d;
  endtask

  task automatic w16(input logic [2:0] s, input logic [15:0] d);
    wr16_en = 1'b1; wr16_sel = s; wr16_data = d;
  endtask

  task automatic idu(input logic [2:0] s, input logic dec);
    idu_en = 1'b1; idu_sel = s; idu_dec = dec;
  endtask

  initial begin
    clr_ops();
    reset = 1'b1; rd8_sel = 8'h00; rd16_sel = 6'h00;
    step();
    reset = 1'b0;
    // Put state away from reset, then reset mid-operation
    w16(R16_PC, 16'h4000); w8(R8_A, 8'h99); exx = 1'b1;
    step();
    exo(K_MB, 16'h0001); exo(K_PC, 16'h4000); exo(K_A, 16'h0099);
    reset = 1'b1; w16(R16_BC, 16'h1234); exx = 1'b1;
    step();
    reset = 1'b0;
    ex16(0, R16_BC, 16'h0000); ex16(1, R16_SP, 16'hFFFE);
    exo(K_PC, 16'h0000); exo(K_SP, 16'hFFFE); exo(K_A, 16'h0000); exo(K_F, 16'h0000);
    exo(K_AFB, 16'h0000); exo(K_MB, 16'h0000);
    ex8(0, R8_R, 8'h00); ex8(1, R8_I, 8'h00);
    step();
    // Bank toggling
    w16(R16_BC, 16'h1122);
    step();
    ex16(0, R16_BC, 16'h1122); exo(K_MB, 16'h0000); exx = 1'b1;
    step();
    ex16(0, R16_BC, 16'h0000); exo(K_MB, 16'h0001); w16(R16_BC, 16'h3344);
    step();
    ex16(0, R16_BC, 16'h3344); exx = 1'b1;
    step();
    ex16(0, R16_BC, 16'h1122); exo(K_MB, 16'h0000); exx = 1'b1;
    step();
    ex16(0, R16_BC, 16'h3344); exo(K_MB, 16'h0001); exx = 1'b1;
    step();
    // EX DE,HL with a concurrent byte write to D
    w16(R16_DE, 16'hAAAA);
    step();
    w16(R16_HL, 16'h5555);
    step();
    ex16(0, R16_DE, 16'hAAAA); ex16(1, R16_HL, 16'h5555);
    ex_de_hl = 1'b1; w8(R8_D, 8'h77);
    step();
    ex16(0, R16_DE, 16'h7755); ex16(1, R16_HL, 16'hAAAA);
    ex8(0, R8_D, 8'h77); ex8(1, R8_L, 8'hAA);
    w16(R16_SP, 16'h0000);
    step();
    // IDU wrap cases; F must be untouched
    exo(K_SP, 16'h0000); idu(R16_SP, 1'b1); flags_we = 1'b1; flags_in = 8'h5A;
    step();
    exo(K_SP, 16'hFFFF); exo(K_F, 16'h005A); w16(R16_HL, 16'hFFFF);
    step();
    ex16(0, R16_HL, 16'hFFFF); idu(R16_HL, 1'b0);
    step();
    ex16(0, R16_HL, 16'h0000); ex16(1, R16_DE, 16'h7755); exo(K_F, 16'h005A);
    idu(R16_BC, 1'b1);
    step();
    ex16(0, R16_BC, 16'h1121); idu(R16_PC, 1'b1);
    step();
    exo(K_PC, 16'hFFFF); pc_inc = 1'b1;
    step();
    exo(K_PC, 16'h0000); w16(R16_PC, 16'h1000); pc_inc = 1'b1;
    step();
    exo(K_PC, 16'h1000); idu(R16_PC, 1'b1); pc_inc = 1'b1;
    step();
    // R refresh counter
    exo(K_PC, 16'h0FFF); w8(R8_R, 8'hFF);
    step();
    ex8(0, R8_R, 8'hFF); r_inc = 1'b1;
    step();
    ex8(0, R8_R, 8'h80); w8(R8_R, 8'h7F);
    step();
    ex8(0, R8_R, 8'h7F); r_inc = 1'b1;
    step();
    ex8(0, R8_R, 8'h00); w8(R8_R, 8'h10); r_inc = 1'b1;
    step();
    // Same-cycle F priority; reads in this cycle see the old values
    ex8(0, R8_R, 8'h10); exo(K_A, 16'h0000); exo(K_F, 16'h005A); ex16(1, R16_AF, 16'h005A);
    w8(R8_F, 8'h00); flags_we = 1'b1; flags_in = 8'hC5; w16(R16_AF, 16'h12FF);
    step();
    exo(K_A, 16'h0012); exo(K_F, 16'h00FF); ex16(0, R16_AF, 16'h12FF);
    ex_af = 1'b1; w8(R8_A, 8'h33);
    step();
    exo(K_AFB, 16'h0001); exo(K_A, 16'h0000); exo(K_F, 16'h0000); ex_af = 1'b1;
    step();
    exo(K_AFB, 16'h0000); exo(K_A, 16'h0033); exo(K_F, 16'h00FF);
    w16(R16_DE, 16'h0102); w8(R8_E, 8'h99); idu(R16_DE, 1'b0);
    step();
    ex16(0, R16_DE, 16'h0102); w8(4'd14, 8'hFF);
    ex8(0, 4'd14, 8'h00); ex8(1, 4'd15, 8'h00);
    step();
    ex8(0, R8_I, 8'h00); ex16(1, R16_DE, 16'h0102); w16(R16_IX, 16'hBEEF);
    step();
    ex16(0, R16_IX, 16'hBEEF); ex8(1, R8_IXL, 8'hEF); w8(R8_IYH, 8'h5C);
    step();
    ex16(0, R16_IY, 16'h5C00);
    step();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
